// File: rtl/fpga_pkg.sv
// Shared types and frame field layout for the MCU-to-framebuffer SPI command path.
package fpga_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_WRITE = 4'h1,
        OP_CLEAR = 4'h2
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR
    } state_t;

    localparam int COLOR_W_DEF = 12;
    localparam int FRAME_BITS  = 32;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int COL_LSB = 16;
    localparam int X_MSB   = 15;
    localparam int X_LSB   = 8;
    localparam int Y_MSB   = 7;
    localparam int Y_LSB   = 0;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sr <= '0;
        else        sr <= {sr[1:0], d};
    end

    // sr[2] is the previous synced value, used only for edge detection
    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI slave that turns 32-bit MCU commands into framebuffer write strobes in the VGA clock domain.
module spi_pixel_rx
    import fpga_pkg::*;
#(
    parameter int FB_W    = 160,
    parameter int FB_H    = 120,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    input  logic               ce,
    output logic               sdo,
    output logic               we,
    output logic [7:0]         wx,
    output logic [6:0]         wy,
    output logic [COLOR_W-1:0] wdata,
    output logic               busy
);

    localparam logic [7:0] X_MAX = 8'(FB_W - 1);
    localparam logic [6:0] Y_MAX = 7'(FB_H - 1);

    logic sck_q, sck_rise, sck_fall;
    logic ce_q, ce_rise, ce_fall;
    logic [1:0] sdi_sr;
    logic sdi_q;

    logic [FRAME_BITS-1:0] shreg;
    logic [5:0] bit_cnt;
    logic frame_done;

    logic [FRAME_BITS-1:0] pend_frame;
    logic pending, overflow, accept;

    op_t p_op;
    logic [7:0] p_x;
    logic [6:0] p_y;
    logic [COLOR_W-1:0] p_col;
    logic in_range;

    state_t state, state_nx;
    logic [7:0] cur_x;
    logic [6:0] cur_y;
    logic [COLOR_W-1:0] cur_color;
    logic [7:0] sts;
    logic unused_bits;

    spi_sync_edge u_sck_sync (.clk(clk), .reset(reset), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge u_ce_sync  (.clk(clk), .reset(reset), .d(ce),  .q(ce_q),  .rise(ce_rise),  .fall(ce_fall));

    // sdi gets the same two-flop delay as sck so the sampled bit lines up with the sck rise pulse
    always_ff @(posedge clk) begin
        sdi_sr <= {sdi_sr[0], sdi};
    end
    assign sdi_q = sdi_sr[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (ce_rise || ce_fall) begin
                bit_cnt <= '0;
            end else if (ce_q && sck_rise && bit_cnt != 6'(FRAME_BITS)) begin
                bit_cnt    <= bit_cnt + 6'd1;
                frame_done <= (bit_cnt == 6'(FRAME_BITS - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce_q && sck_rise && bit_cnt != 6'(FRAME_BITS))
            shreg <= {shreg[FRAME_BITS-2:0], sdi_q};
    end

    assign p_op     = op_t'(pend_frame[OP_MSB:OP_LSB]);
    assign p_col    = pend_frame[COL_LSB +: COLOR_W];
    assign p_x      = pend_frame[X_MSB:X_LSB];
    assign p_y      = pend_frame[Y_MSB-1:Y_LSB];
    assign in_range = (p_x <= X_MAX) && (p_y <= Y_MAX);
    assign accept   = (state == ST_IDLE) && pending;

    // A slot freed by accept in the same cycle can take the new frame without overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (frame_done && pending && !accept) overflow <= 1'b1;
            if (frame_done && (!pending || accept)) pending <= 1'b1;
            else if (accept)                         pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (frame_done && (!pending || accept)) pend_frame <= shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (pending && p_op == OP_WRITE && in_range) state_nx = ST_WRITE;
                else if (pending && p_op == OP_CLEAR)        state_nx = ST_CLEAR;
            end
            ST_WRITE: state_nx = ST_IDLE;
            ST_CLEAR: if (cur_x == X_MAX && cur_y == Y_MAX) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        we    = (state == ST_WRITE) || (state == ST_CLEAR);
        busy  = (state == ST_CLEAR);
        wx    = cur_x;
        wy    = cur_y;
        wdata = cur_color;
    end

    // Sweep holds at the last pixel when it finishes rather than wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_x     <= '0;
            cur_y     <= '0;
            cur_color <= '0;
        end else if (state == ST_IDLE && pending && p_op == OP_WRITE && in_range) begin
            cur_x     <= p_x;
            cur_y     <= p_y;
            cur_color <= p_col;
        end else if (state == ST_IDLE && pending && p_op == OP_CLEAR) begin
            cur_x     <= '0;
            cur_y     <= '0;
            cur_color <= p_col;
        end else if (state == ST_CLEAR) begin
            if (cur_x != X_MAX) begin
                cur_x <= cur_x + 8'd1;
            end else if (cur_y != Y_MAX) begin
                cur_x <= '0;
                cur_y <= cur_y + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                sts <= '0;
        else if (ce_rise)          sts <= {busy, overflow, pending, 5'b0};
        else if (ce_q && sck_fall) sts <= {sts[6:0], 1'b0};
    end

    assign sdo = ce_q & sts[7];

    assign unused_bits = ^{sck_q, pend_frame[Y_MSB]};

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Directed bench for spi_pixel_rx: MCU-side SPI driver plus a framebuffer strobe monitor.
module tb_spi_pixel_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        ce = 1'b0;
    logic        sdo, we, busy;
    logic [7:0]  wx;
    logic [6:0]  wy;
    logic [11:0] wdata;

    int checks = 0;
    int errors = 0;

    int we_cnt = 0;
    int busy_cnt = 0;
    int raster_bad = 0;
    int rx = 0;
    int ry = 0;
    logic [7:0]  last_x = 8'h00;
    logic [6:0]  last_y = 7'h00;
    logic [11:0] last_d = 12'h000;

    spi_pixel_rx #(.FB_W(160), .FB_H(120), .COLOR_W(12)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ce(ce),
        .sdo(sdo), .we(we), .wx(wx), .wy(wy), .wdata(wdata), .busy(busy)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (we) begin
            we_cnt++;
            last_x = wx;
            last_y = wy;
            last_d = wdata;
            if (busy) begin
                if (int'(wx) != rx || int'(wy) != ry) raster_bad++;
                if (rx == 159) begin rx = 0; ry++; end
                else rx++;
            end
        end else if (!busy) begin
            rx = 0;
            ry = 0;
        end
    end

    // sck runs at clk/8; sdo is sampled just before each sck rise, as the MCU would
    task automatic spi_xfer(input logic [31:0] data, input int nbits, output logic [7:0] st);
        st = 8'h00;
        @(negedge clk);
        ce = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdi = data[31-i];
            repeat (4) @(negedge clk);
            if (i < 8) st[7-i] = sdo;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        ce  = 1'b0;
        sdi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_clear_done(input string name);
        int n;
        n = 0;
        while (busy && n < 25000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: clear sweep still busy after %0d cycles, required busy=0", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (sdo !== 1'b0)      begin errors++; $display("FAIL reset_sdo: got %b, required 0", sdo); end
        if (we !== 1'b0)       begin errors++; $display("FAIL reset_we: got %b, required 0", we); end
        if (wx !== 8'd0)       begin errors++; $display("FAIL reset_wx: got %0d, required 0", wx); end
        if (wy !== 7'd0)       begin errors++; $display("FAIL reset_wy: got %0d, required 0", wy); end
        if (wdata !== 12'h000) begin errors++; $display("FAIL reset_wdata: got %h, required 000", wdata); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int c0;
        logic [7:0] st;
        c0 = we_cnt;
        spi_xfer(32'h1F00_0A05, 32, st);
        repeat (20) @(negedge clk);
        checks += 4;
        if (we_cnt - c0 != 1)   begin errors++; $display("FAIL write_count: got %0d strobes, required 1", we_cnt - c0); end
        if (last_x !== 8'd10)   begin errors++; $display("FAIL write_wx: got %0d, required 10", last_x); end
        if (last_y !== 7'd5)    begin errors++; $display("FAIL write_wy: got %0d, required 5", last_y); end
        if (last_d !== 12'hF00) begin errors++; $display("FAIL write_wdata: got %h, required F00", last_d); end
    endtask

    task automatic test_clear();
        int c0, b0, r0;
        logic [7:0] st;
        c0 = we_cnt;
        b0 = busy_cnt;
        r0 = raster_bad;
        spi_xfer(32'h200F_0000, 32, st);
        wait_clear_done("clear_done");
        repeat (10) @(negedge clk);
        checks += 6;
        if (we_cnt - c0 != 19200)   begin errors++; $display("FAIL clear_strobes: got %0d, required 19200", we_cnt - c0); end
        if (busy_cnt - b0 != 19200) begin errors++; $display("FAIL clear_busy_cycles: got %0d, required 19200", busy_cnt - b0); end
        if (raster_bad != r0)       begin errors++; $display("FAIL clear_raster: got %0d out-of-order strobes, required 0", raster_bad - r0); end
        if (last_x !== 8'd159)      begin errors++; $display("FAIL clear_last_x: got %0d, required 159", last_x); end
        if (last_y !== 7'd119)      begin errors++; $display("FAIL clear_last_y: got %0d, required 119", last_y); end
        if (last_d !== 12'h00F)     begin errors++; $display("FAIL clear_wdata: got %h, required 00F", last_d); end
    endtask

    task automatic test_abort();
        int c0;
        logic [7:0] st;
        c0 = we_cnt;
        spi_xfer(32'h1FFF_0707, 20, st);
        repeat (20) @(negedge clk);
        checks++;
        if (we_cnt != c0) begin errors++; $display("FAIL abort_no_strobe: got %0d strobes, required 0", we_cnt - c0); end
        c0 = we_cnt;
        spi_xfer(32'h10F0_0000, 32, st);
        repeat (20) @(negedge clk);
        checks += 4;
        if (we_cnt - c0 != 1)   begin errors++; $display("FAIL abort_next_count: got %0d strobes, required 1", we_cnt - c0); end
        if (last_x !== 8'd0)    begin errors++; $display("FAIL abort_next_wx: got %0d, required 0", last_x); end
        if (last_y !== 7'd0)    begin errors++; $display("FAIL abort_next_wy: got %0d, required 0", last_y); end
        if (last_d !== 12'h0F0) begin errors++; $display("FAIL abort_next_wdata: got %h, required 0F0", last_d); end
    endtask

    task automatic test_range_overflow();
        int c0;
        logic [7:0] st;
        c0 = we_cnt;
        spi_xfer(32'h1123_C805, 32, st);
        repeat (20) @(negedge clk);
        checks++;
        if (we_cnt != c0) begin errors++; $display("FAIL range_x200: got %0d strobes, required 0", we_cnt - c0); end
        c0 = we_cnt;
        spi_xfer(32'h200F_0000, 32, st);
        spi_xfer(32'h10A0_0304, 32, st);
        spi_xfer(32'h1555_0506, 32, st);
        spi_xfer(32'h0000_0000, 8, st);
        checks += 2;
        if (st !== 8'hE0) begin errors++; $display("FAIL overflow_status: got %h, required E0", st); end
        if (sdo !== 1'b0) begin errors++; $display("FAIL sdo_idle_ce_low: got %b, required 0", sdo); end
        wait_clear_done("overflow_clear_done");
        repeat (20) @(negedge clk);
        checks += 4;
        if (we_cnt - c0 != 19201) begin errors++; $display("FAIL overflow_strobes: got %0d, required 19201", we_cnt - c0); end
        if (last_x !== 8'd3)      begin errors++; $display("FAIL queued_wx: got %0d, required 3", last_x); end
        if (last_y !== 7'd4)      begin errors++; $display("FAIL queued_wy: got %0d, required 4", last_y); end
        if (last_d !== 12'h0A0)   begin errors++; $display("FAIL queued_wdata: got %h, required 0A0", last_d); end
    endtask

    task automatic test_reset_mid_clear();
        int n, c0;
        logic [7:0] st;
        spi_xfer(32'h2123_0000, 32, st);
        n = 0;
        while (!(we && wy == 7'd40) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(we && wy == 7'd40)) begin
            errors++;
            $display("FAIL midclear_reach_y40: got wy=%0d we=%b, required wy=40 we=1", wy, we);
        end
        reset = 1'b0;
        #1;
        checks += 4;
        if (we !== 1'b0)   begin errors++; $display("FAIL midclear_we: got %b, required 0", we); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midclear_busy: got %b, required 0", busy); end
        if (wx !== 8'd0)   begin errors++; $display("FAIL midclear_wx: got %0d, required 0", wx); end
        if (wy !== 7'd0)   begin errors++; $display("FAIL midclear_wy: got %0d, required 0", wy); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        c0 = we_cnt;
        repeat (200) @(negedge clk);
        checks++;
        if (we_cnt != c0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_no_resume: got %0d strobes busy=%b, required 0 strobes busy=0", we_cnt - c0, busy);
        end
    endtask

    task automatic test_status();
        logic [7:0] st;
        spi_xfer(32'h0000_0000, 8, st);
        checks++;
        if (st !== 8'h00) begin errors++; $display("FAIL status_idle: got %h, required 00", st); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_clear();
        test_abort();
        test_range_overflow();
        test_reset_mid_clear();
        test_status();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
